// File: rtl/int_arbiter_if.sv
// ---------------------------------------------------------------------------
// int_arbiter_if
// Bundles the interrupt request, configuration and CPU handshake signals
// that connect the interrupt arbiter to the processor control logic.
//
// Signals
//   irq_req      [3:0]  level requests, one per source (kbd, display, timer, ext)
//   irq_en       [3:0]  per-source global enable mask
//   cfg_we              priority register write strobe
//   cfg_sel      [1:0]  source index to write
//   cfg_pri      [2:0]  priority value to write
//   psr_pri      [2:0]  current processor priority level
//   int_ack             control FSM takes the offered interrupt
//   rti_done            return from an interrupt service routine completed
//   int_pending         an interrupt is offered to the CPU
//   int_vector   [7:0]  vector of the offered source
//   int_priority [2:0]  priority of the offered source
//   in_service   [3:0]  sources currently being serviced
//
// Modports
//   master : processor side, drives requests / config / handshake
//   slave  : arbiter side, drives the offer and in-service mask
// ---------------------------------------------------------------------------
interface int_arbiter_if;
   logic [3:0] irq_req;
   logic [3:0] irq_en;
   logic       cfg_we;
   logic [1:0] cfg_sel;
   logic [2:0] cfg_pri;
   logic [2:0] psr_pri;
   logic       int_ack;
   logic       rti_done;
   logic       int_pending;
   logic [7:0] int_vector;
   logic [2:0] int_priority;
   logic [3:0] in_service;

   modport master (
      output irq_req, irq_en, cfg_we, cfg_sel, cfg_pri, psr_pri, int_ack, rti_done,
      input  int_pending, int_vector, int_priority, in_service
   );

   modport slave (
      input  irq_req, irq_en, cfg_we, cfg_sel, cfg_pri, psr_pri, int_ack, rti_done,
      output int_pending, int_vector, int_priority, in_service
   );
endinterface

// File: rtl/int_arbiter.sv
// ---------------------------------------------------------------------------
// int_arbiter
// Four-source prioritised interrupt arbiter. Each source has a programmable
// 3-bit priority. A source competes when it requests, is enabled, is not
// already in service and its priority is strictly above the processor
// priority level. The winner is offered to the CPU through int_pending /
// int_vector / int_priority until it is acknowledged, withdrawn, or beaten
// by a strictly higher-priority source. Acknowledged sources are tracked in
// in_service so nested interrupts of higher priority can still be offered;
// rti_done retires the highest-priority serviced source.
//
// Ports
//   clk   system clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   int_arbiter_if.slave, see the interface file for the signal list
// ---------------------------------------------------------------------------
module int_arbiter (
   input logic          clk,
   input logic          rst,
   int_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACKD = 2'd2
   } state_t;

   state_t     state;
   state_t     state_next;

   logic [2:0] pri_q [4];

   logic       pending_q;
   logic       pending_d;
   logic [1:0] idx_q;
   logic [1:0] idx_d;
   logic [7:0] vec_q;
   logic [7:0] vec_d;
   logic [2:0] prio_q;
   logic [2:0] prio_d;
   logic [3:0] isv_q;
   logic [3:0] isv_d;

   logic [3:0] cand;
   logic       win_found;
   logic [1:0] win_idx;
   logic [2:0] win_pri;

   logic       svc_found;
   logic [1:0] svc_idx;
   logic [2:0] svc_pri;
   logic [3:0] rti_clear;

   // Candidate qualification. Priority 0 can never exceed psr_pri, so it
   // drops out naturally from the strict comparison.
   always_comb begin
      cand = '0;
      for (int i = 0; i < 4; i++) begin
         cand[i] = bus.irq_req[i] & bus.irq_en[i] & ~isv_q[i] &
                   (pri_q[i] > bus.psr_pri);
      end
   end

   // Winner search. Scanning from the highest index down with >= lets a
   // lower index overwrite an equal-priority result, so ties go to the
   // lowest index.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 2'd0;
      win_pri   = 3'd0;
      for (int i = 3; i >= 0; i--) begin
         if (cand[i] && (!win_found || pri_q[i] >= win_pri)) begin
            win_found = 1'b1;
            win_idx   = 2'(i);
            win_pri   = pri_q[i];
         end
      end
   end

   // Pick the serviced source that rti_done retires: the highest-priority
   // bit in in_service, ties to the lowest index, same scan as above.
   always_comb begin
      svc_found = 1'b0;
      svc_idx   = 2'd0;
      svc_pri   = 3'd0;
      for (int i = 3; i >= 0; i--) begin
         if (isv_q[i] && (!svc_found || pri_q[i] >= svc_pri)) begin
            svc_found = 1'b1;
            svc_idx   = 2'(i);
            svc_pri   = pri_q[i];
         end
      end
      rti_clear = (bus.rti_done && svc_found) ? (4'b0001 << svc_idx) : 4'b0000;
   end

   // Next-state and next-output logic. The rti clear is folded into the
   // default so an acknowledge in the same cycle sets its bit on top of it.
   always_comb begin
      state_next = state;
      idx_d      = idx_q;
      vec_d      = vec_q;
      prio_d     = prio_q;
      isv_d      = isv_q & ~rti_clear;
      pending_d  = 1'b0;

      case (state)
         IDLE: begin
            if (win_found) begin
               idx_d      = win_idx;
               vec_d      = {6'b100000, win_idx};
               prio_d     = win_pri;
               state_next = PEND;
            end
         end
         PEND: begin
            // The ack wins over withdrawal and re-latch, and always refers to
            // the source latched before this edge.
            if (bus.int_ack) begin
               isv_d[idx_q] = 1'b1;
               state_next   = ACKD;
            end else if (!cand[idx_q]) begin
               state_next = IDLE;
            end else if (win_found && (win_pri > prio_q)) begin
               idx_d  = win_idx;
               vec_d  = {6'b100000, win_idx};
               prio_d = win_pri;
            end
         end
         ACKD: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      pending_d = (state_next == PEND);
   end

   // State and offer registers; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pending_q <= 1'b0;
         idx_q     <= 2'd0;
         vec_q     <= 8'h00;
         prio_q    <= 3'd0;
         isv_q     <= 4'b0000;
      end else begin
         state     <= state_next;
         pending_q <= pending_d;
         idx_q     <= idx_d;
         vec_q     <= vec_d;
         prio_q    <= prio_d;
         isv_q     <= isv_d;
      end
   end

   // Per-source priority registers. A write is only seen by the arbitration
   // logic from the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pri_q[0] <= 3'd4;
         pri_q[1] <= 3'd3;
         pri_q[2] <= 3'd2;
         pri_q[3] <= 3'd1;
      end else if (bus.cfg_we) begin
         pri_q[bus.cfg_sel] <= bus.cfg_pri;
      end
   end

   assign bus.int_pending  = pending_q;
   assign bus.int_vector   = vec_q;
   assign bus.int_priority = prio_q;
   assign bus.in_service   = isv_q;

endmodule
